pc_fetch_ctrl: RTL and testbench

//  Parametrised next-generation PC/fetch-request unit for the IF stage. Holds the architectural PC,

---
 rtl/pc_fetch_ctrl_pkg.sv | 25 ++
 rtl/pc_fetch_ctrl_target_sel.sv | 57 +++++
 rtl/pc_fetch_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_ctrl_pkg
// Purpose  : Shared definitions for the IF-stage PC/fetch-request unit:
//            fetch FSM state encodings and the default reset/exception vectors.
// Revision : 1.0 - initial release
// ============================================================================
package pc_fetch_ctrl_pkg;

    localparam int unsigned C_STATE_W = 2;

    // Fetch FSM states
    localparam logic [C_STATE_W-1:0] S_BOOT  = 2'd0;  // first cycle after reset
    localparam logic [C_STATE_W-1:0] S_REQ   = 2'd1;  // request outstanding
    localparam logic [C_STATE_W-1:0] S_STALL = 2'd2;  // IF stalled, no request
    localparam logic [C_STATE_W-1:0] S_ADEL  = 2'd3;  // misaligned pc trapped

    // Default vectors / geometry
    localparam logic [31:0] C_DEF_RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] C_DEF_EXC_VECTOR   = 32'hBFC0_0380;
    localparam int unsigned C_DEF_INC          = 4;
    localparam int unsigned C_DEF_ALIGN_BITS   = 2;

endpackage
`default_nettype wire

// File: rtl/pc_fetch_ctrl_target_sel.sv
`default_nettype none
// ============================================================================
// Module   : pc_target_sel
// Purpose  : Combinational next-PC selection for the fetch unit.
//            Priority: exc > redirect > pending redirect > pc + INC.
//            Also flags a selected target whose low ALIGN_BITS are non-zero.
// Ports    : exc, redirect, redirect_pc - current-cycle control-flow events
//            pend, pend_pc              - buffered redirect from a busy request
//            pc                         - current architectural PC
//            tgt                        - selected next PC
//            misaligned                 - tgt violates alignment
// Revision : 1.0 - initial release
// ============================================================================
module pc_target_sel
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int unsigned     WIDTH      = 32,
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(C_DEF_EXC_VECTOR),
    parameter int unsigned     INC        = C_DEF_INC,
    parameter int unsigned     ALIGN_BITS = C_DEF_ALIGN_BITS
) (
    input  logic             exc,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             pend,
    input  logic [WIDTH-1:0] pend_pc,
    input  logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] tgt,
    output logic             misaligned
);

    logic [WIDTH-1:0] w_seq_pc;

    // Wraps modulo 2^WIDTH by construction
    assign w_seq_pc = pc + WIDTH'(INC);

    always_comb begin
        tgt = w_seq_pc;
        if (exc) begin
            tgt = EXC_VECTOR;
        end else if (redirect) begin
            tgt = redirect_pc;
        end else if (pend) begin
            tgt = pend_pc;
        end
    end

    generate
        if (ALIGN_BITS > 0) begin : g_align_chk
            assign misaligned = |tgt[ALIGN_BITS-1:0];
        end else begin : g_no_align_chk
            assign misaligned = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_ctrl
// Purpose  : IF-stage PC holder and instruction-fetch request generator.
//            Issues one request per PC, advances by increment, redirect or
//            exception vector, buffers redirects that arrive while a request
//            is outstanding (flagging the accepted fetch for squash) and traps
//            misaligned PCs as AdEL without issuing a request.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            en                - pipeline advance enable (0 = IF stall)
//            redirect/_pc      - branch/jump redirect strobe and target
//            exc               - exception/flush strobe (target EXC_VECTOR)
//            inst_addr_ok      - memory accepted current request
//            inst_req/_addr    - registered request and address
//            pc                - architectural PC
//            fetch_pc          - PC of the last accepted request
//            squash            - last accepted fetch is wrong-path (1 cycle)
//            adel              - misaligned pc trapped, held until exc
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(C_DEF_RESET_VECTOR),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(C_DEF_EXC_VECTOR),
    parameter int unsigned      INC          = C_DEF_INC,
    parameter int unsigned      ALIGN_BITS   = C_DEF_ALIGN_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             exc,
    input  logic             inst_addr_ok,
    output logic             inst_req,
    output logic [WIDTH-1:0] inst_addr,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] fetch_pc,
    output logic             squash,
    output logic             adel
);

    logic [C_STATE_W-1:0] r_state;
    logic                 r_inst_req;
    logic [WIDTH-1:0]     r_inst_addr;
    logic [WIDTH-1:0]     r_pc;
    logic [WIDTH-1:0]     r_fetch_pc;
    logic                 r_squash;
    logic                 r_adel;
    logic                 r_pend;
    logic                 r_pend_exc;   // buffered event is an exception
    logic [WIDTH-1:0]     r_pend_pc;

    logic [WIDTH-1:0]     w_tgt;
    logic                 w_tgt_misaligned;
    logic                 w_handshake;
    logic                 w_event;

    assign w_handshake = r_inst_req & inst_addr_ok;
    assign w_event     = exc | redirect;

    pc_target_sel #(
        .WIDTH      (WIDTH),
        .EXC_VECTOR (EXC_VECTOR),
        .INC        (INC),
        .ALIGN_BITS (ALIGN_BITS)
    ) u_target_sel (
        .exc         (exc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pend        (r_pend),
        .pend_pc     (r_pend_pc),
        .pc          (r_pc),
        .tgt         (w_tgt),
        .misaligned  (w_tgt_misaligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_BOOT;
            r_inst_req  <= 1'b0;
            r_inst_addr <= RESET_VECTOR;
            r_pc        <= RESET_VECTOR;
            r_fetch_pc  <= RESET_VECTOR;
            r_squash    <= 1'b0;
            r_adel      <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_exc  <= 1'b0;
            r_pend_pc   <= RESET_VECTOR;
        end else begin
            r_squash <= 1'b0;
            case (r_state)
                // No request in flight: events load the pc directly and
                // nothing needs squashing. pend is always clear here.
                S_BOOT, S_STALL: begin
                    if (w_event) begin
                        r_pc <= w_tgt;
                        if (w_tgt_misaligned) begin
                            r_state    <= S_ADEL;
                            r_adel     <= 1'b1;
                            r_inst_req <= 1'b0;
                        end else if (en) begin
                            r_state     <= S_REQ;
                            r_inst_req  <= 1'b1;
                            r_inst_addr <= w_tgt;
                        end else begin
                            r_state <= S_STALL;
                        end
                    end else if (en) begin
                        r_state     <= S_REQ;
                        r_inst_req  <= 1'b1;
                        r_inst_addr <= r_pc;
                    end else begin
                        r_state <= S_STALL;
                    end
                end

                // Request outstanding: address is frozen until accepted.
                S_REQ: begin
                    if (w_handshake) begin
                        r_fetch_pc <= r_pc;
                        r_pc       <= w_tgt;
                        // The accepted fetch followed the old pc; any
                        // control-flow change seen during it is wrong-path.
                        r_squash   <= w_event | r_pend;
                        r_pend     <= 1'b0;
                        r_pend_exc <= 1'b0;
                        if (w_tgt_misaligned) begin
                            r_state    <= S_ADEL;
                            r_adel     <= 1'b1;
                            r_inst_req <= 1'b0;
                        end else if (en) begin
                            r_state     <= S_REQ;
                            r_inst_addr <= w_tgt;
                        end else begin
                            r_state    <= S_STALL;
                            r_inst_req <= 1'b0;
                        end
                    end else if (exc) begin
                        r_pend     <= 1'b1;
                        r_pend_exc <= 1'b1;
                        r_pend_pc  <= EXC_VECTOR;
                    end else if (redirect && !r_pend_exc) begin
                        // A buffered exception must not be displaced by a
                        // later redirect.
                        r_pend    <= 1'b1;
                        r_pend_pc <= redirect_pc;
                    end
                end

                // Trapped: only an exception recovers.
                S_ADEL: begin
                    if (exc) begin
                        r_pc   <= EXC_VECTOR;
                        r_adel <= 1'b0;
                        if (en) begin
                            r_state     <= S_REQ;
                            r_inst_req  <= 1'b1;
                            r_inst_addr <= EXC_VECTOR;
                        end else begin
                            r_state <= S_STALL;
                        end
                    end
                end

                default: begin
                    r_state    <= S_BOOT;
                    r_inst_req <= 1'b0;
                end
            endcase
        end
    end

    assign inst_req  = r_inst_req;
    assign inst_addr = r_inst_addr;
    assign pc        = r_pc;
    assign fetch_pc  = r_fetch_pc;
    assign squash    = r_squash;
    assign adel      = r_adel;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_ctrl
// Purpose  : Directed self-checking bench for pc_fetch_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        exc;
    logic        inst_addr_ok;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] pc;
    logic [31:0] fetch_pc;
    logic        squash;
    logic        adel;

    int n_tests = 0;
    int n_fail  = 0;

    pc_fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .exc          (exc),
        .inst_addr_ok (inst_addr_ok),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .pc           (pc),
        .fetch_pc     (fetch_pc),
        .squash       (squash),
        .adel         (adel)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled and inputs changed 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b1; redirect = 1'b0; redirect_pc = '0;
        exc = 1'b0; inst_addr_ok = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (pc !== 32'hBFC00000) begin n_fail++; $display("FAIL reset_pc: got %h exp %h", pc, 32'hBFC00000); end
        n_tests++; if (inst_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b exp 0", inst_req); end
        n_tests++; if (fetch_pc !== 32'hBFC00000) begin n_fail++; $display("FAIL reset_fetch_pc: got %h exp %h", fetch_pc, 32'hBFC00000); end
        n_tests++; if ({squash, adel} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b exp 00", {squash, adel}); end
        rst = 1'b0;
        step();
        n_tests++; if (inst_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b exp 1", inst_req); end
        n_tests++; if (inst_addr !== 32'hBFC00000) begin n_fail++; $display("FAIL seq_addr0: got %h exp %h", inst_addr, 32'hBFC00000); end
        step();
        n_tests++; if (inst_addr !== 32'hBFC00004) begin n_fail++; $display("FAIL seq_addr1: got %h exp %h", inst_addr, 32'hBFC00004); end
        n_tests++; if (fetch_pc !== 32'hBFC00000) begin n_fail++; $display("FAIL seq_fetch_pc: got %h exp %h", fetch_pc, 32'hBFC00000); end
        step();
        n_tests++; if (inst_addr !== 32'hBFC00008) begin n_fail++; $display("FAIL seq_addr2: got %h exp %h", inst_addr, 32'hBFC00008); end
        n_tests++; if (squash !== 1'b0) begin n_fail++; $display("FAIL seq_squash: got %b exp 0", squash); end
    endtask

    task automatic test_redirect_pending();
        do_reset();
        rst = 1'b0; inst_addr_ok = 1'b0;
        step();
        redirect = 1'b1; redirect_pc = 32'h80001000;
        step();
        redirect = 1'b0;
        n_tests++; if (inst_addr !== 32'hBFC00000 || inst_req !== 1'b1) begin n_fail++; $display("FAIL pend_hold1: got req %b addr %h exp 1 %h", inst_req, inst_addr, 32'hBFC00000); end
        step(); step();
        n_tests++; if (inst_addr !== 32'hBFC00000) begin n_fail++; $display("FAIL pend_hold3: got %h exp %h", inst_addr, 32'hBFC00000); end
        n_tests++; if (squash !== 1'b0) begin n_fail++; $display("FAIL pend_early_squash: got %b exp 0", squash); end
        inst_addr_ok = 1'b1;
        step();
        n_tests++; if (squash !== 1'b1) begin n_fail++; $display("FAIL pend_squash: got %b exp 1", squash); end
        n_tests++; if (inst_addr !== 32'h80001000) begin n_fail++; $display("FAIL pend_target: got %h exp %h", inst_addr, 32'h80001000); end
        n_tests++; if (fetch_pc !== 32'hBFC00000) begin n_fail++; $display("FAIL pend_fetch_pc: got %h exp %h", fetch_pc, 32'hBFC00000); end
        step();
        n_tests++; if (squash !== 1'b0) begin n_fail++; $display("FAIL pend_squash_pulse: got %b exp 0", squash); end
        n_tests++; if (inst_addr !== 32'h80001004) begin n_fail++; $display("FAIL pend_after: got %h exp %h", inst_addr, 32'h80001004); end
    endtask

    task automatic test_exc_redirect();
        do_reset();
        rst = 1'b0;
        step();
        exc = 1'b1; redirect = 1'b1; redirect_pc = 32'h80002000;
        step();
        exc = 1'b0; redirect = 1'b0;
        n_tests++; if (inst_addr !== 32'hBFC00380) begin n_fail++; $display("FAIL exc_wins: got %h exp %h", inst_addr, 32'hBFC00380); end
        n_tests++; if (squash !== 1'b1) begin n_fail++; $display("FAIL exc_squash: got %b exp 1", squash); end
        // Buffered exception must survive a later redirect
        inst_addr_ok = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h80003000;
        step();
        redirect = 1'b0; exc = 1'b1;
        step();
        exc = 1'b0; redirect = 1'b1; redirect_pc = 32'h80004000;
        step();
        redirect = 1'b0; inst_addr_ok = 1'b1;
        step();
        n_tests++; if (inst_addr !== 32'hBFC00380) begin n_fail++; $display("FAIL pend_exc_kept: got %h exp %h", inst_addr, 32'hBFC00380); end
        n_tests++; if (fetch_pc !== 32'hBFC00380 || squash !== 1'b1) begin n_fail++; $display("FAIL pend_exc_fetch: got %h/%b exp %h/1", fetch_pc, squash, 32'hBFC00380); end
    endtask

    task automatic test_stall();
        do_reset();
        rst = 1'b0;
        step();
        step();
        en = 1'b0;
        step();
        n_tests++; if (inst_req !== 1'b0) begin n_fail++; $display("FAIL stall_req: got %b exp 0", inst_req); end
        n_tests++; if (pc !== 32'hBFC00008) begin n_fail++; $display("FAIL stall_pc: got %h exp %h", pc, 32'hBFC00008); end
        n_tests++; if (fetch_pc !== 32'hBFC00004) begin n_fail++; $display("FAIL stall_fetch_pc: got %h exp %h", fetch_pc, 32'hBFC00004); end
        step();
        n_tests++; if (pc !== 32'hBFC00008 || inst_req !== 1'b0) begin n_fail++; $display("FAIL stall_hold: got %h/%b exp %h/0", pc, inst_req, 32'hBFC00008); end
        redirect = 1'b1; redirect_pc = 32'h80000010;
        step();
        redirect = 1'b0;
        n_tests++; if (pc !== 32'h80000010 || inst_req !== 1'b0) begin n_fail++; $display("FAIL stall_redirect: got %h/%b exp %h/0", pc, inst_req, 32'h80000010); end
        en = 1'b1;
        step();
        n_tests++; if (inst_req !== 1'b1 || inst_addr !== 32'h80000010) begin n_fail++; $display("FAIL stall_resume: got %b/%h exp 1/%h", inst_req, inst_addr, 32'h80000010); end
        n_tests++; if (squash !== 1'b0) begin n_fail++; $display("FAIL stall_no_squash: got %b exp 0", squash); end
    endtask

    task automatic test_adel();
        do_reset();
        rst = 1'b0;
        step();
        redirect = 1'b1; redirect_pc = 32'h80000002;
        step();
        redirect = 1'b0;
        n_tests++; if (adel !== 1'b1 || inst_req !== 1'b0) begin n_fail++; $display("FAIL adel_set: got adel %b req %b exp 1 0", adel, inst_req); end
        n_tests++; if (pc !== 32'h80000002) begin n_fail++; $display("FAIL adel_pc: got %h exp %h", pc, 32'h80000002); end
        redirect = 1'b1; redirect_pc = 32'h80000020;
        step();
        redirect = 1'b0;
        n_tests++; if (adel !== 1'b1 || pc !== 32'h80000002) begin n_fail++; $display("FAIL adel_ignore_redirect: got %b/%h exp 1/%h", adel, pc, 32'h80000002); end
        exc = 1'b1;
        step();
        exc = 1'b0;
        n_tests++; if (adel !== 1'b0 || pc !== 32'hBFC00380) begin n_fail++; $display("FAIL adel_exit: got %b/%h exp 0/%h", adel, pc, 32'hBFC00380); end
        n_tests++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC00380) begin n_fail++; $display("FAIL adel_resume: got %b/%h exp 1/%h", inst_req, inst_addr, 32'hBFC00380); end
    endtask

    task automatic test_rst_mid_request();
        do_reset();
        rst = 1'b0; inst_addr_ok = 1'b0;
        step();
        redirect = 1'b1; redirect_pc = 32'h80005000;
        step();
        redirect = 1'b0; rst = 1'b1;
        step();
        n_tests++; if (inst_req !== 1'b0 || pc !== 32'hBFC00000) begin n_fail++; $display("FAIL rst_mid: got %b/%h exp 0/%h", inst_req, pc, 32'hBFC00000); end
        rst = 1'b0; inst_addr_ok = 1'b1;
        step();
        n_tests++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC00000) begin n_fail++; $display("FAIL rst_mid_req: got %b/%h exp 1/%h", inst_req, inst_addr, 32'hBFC00000); end
        step();
        n_tests++; if (squash !== 1'b0) begin n_fail++; $display("FAIL rst_mid_squash: got %b exp 0", squash); end
        n_tests++; if (inst_addr !== 32'hBFC00004) begin n_fail++; $display("FAIL rst_mid_pend_dropped: got %h exp %h", inst_addr, 32'hBFC00004); end
    endtask

    initial begin
        test_reset();
        test_redirect_pending();
        test_exc_redirect();
        test_stall();
        test_adel();
        test_rst_mid_request();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
